// File: rtl/riscv_crypto_aes_ks_rev.sv
// AES-128 reverse key schedule: walks round keys 10 down to 0 starting from the
// round-10 key, one byte per cycle through a single forward S-box.

module riscv_crypto_aes_fwd_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the top byte, so entry i lives at bit offset 8 * (255 - i).
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb out_byte = SboxTable[{~in_byte, 3'b000} +: 8];

endmodule

module riscv_crypto_aes_ks_rev (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [127:0] key_in,
  input  logic         clear,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StEmit, StSub} state_e;

  state_e       state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic [1:0]   cnt_q;
  logic [23:0]  t_q;
  logic         rk_valid_q, done_q, busy_q, start_ready_q;

  logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3;
  logic [7:0]   sbox_in, sbox_out, rcon;

  riscv_crypto_aes_fwd_sbox u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  always_comb begin
    w0 = key_q[31:0];
    w1 = key_q[63:32];
    w2 = key_q[95:64];
    w3 = key_q[127:96];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    // RotWord: cycle c feeds byte (c+1) mod 4 of p3.
    unique case (cnt_q)
      2'd0: sbox_in = p3[15:8];
      2'd1: sbox_in = p3[23:16];
      2'd2: sbox_in = p3[31:24];
      2'd3: sbox_in = p3[7:0];
    endcase
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    // Byte 3 of t comes straight from the S-box in the last SUB cycle.
    p0 = w0 ^ {sbox_out, t_q} ^ {24'h0, rcon};
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q       <= StIdle;
      key_q         <= '0;
      round_q       <= '0;
      cnt_q         <= '0;
      t_q           <= '0;
      rk_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else if (clear) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rk_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_valid && start_ready_q) begin
            key_q         <= key_in;
            round_q       <= 4'd10;
            state_q       <= StEmit;
            rk_valid_q    <= 1'b1;
            busy_q        <= 1'b1;
            start_ready_q <= 1'b0;
          end
        end
        StEmit: begin
          if (rk_valid_q && rk_ready) begin
            rk_valid_q <= 1'b0;
            if (round_q == 4'd0) begin
              state_q       <= StIdle;
              done_q        <= 1'b1;
              busy_q        <= 1'b0;
              start_ready_q <= 1'b1;
            end else begin
              state_q <= StSub;
              cnt_q   <= 2'd0;
            end
          end
        end
        StSub: begin
          cnt_q <= cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    t_q[7:0]   <= sbox_out;
            2'd1:    t_q[15:8]  <= sbox_out;
            2'd2:    t_q[23:16] <= sbox_out;
            default: begin
              key_q      <= {p3, p2, p1, p0};
              round_q    <= round_q - 4'd1;
              state_q    <= StEmit;
              rk_valid_q <= 1'b1;
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign rk_valid    = rk_valid_q;
  assign rk_data     = key_q;
  assign rk_idx      = round_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/riscv_crypto_aes_ks_rev.md
RISCV_CRYPTO_AES_KS_REV -- requirements
Module: riscv_crypto_aes_ks_rev

Interface
REQ-001 The block SHALL use one clock, g_clk (input, 1 bit), on whose rising edge all state updates.
REQ-002 The block SHALL use g_resetn (input, 1 bit) as its reset: asynchronous, active-low.
REQ-003 The block SHALL have input start_valid (1 bit): request to begin a reverse key schedule.
REQ-004 The block SHALL have output start_ready (1 bit): high only in IDLE.
REQ-005 The block SHALL have input key_in (128 bits): AES-128 round-10 key; byte k at bits [8k+7:8k], word j at bits [32j+31:32j].
REQ-006 The block SHALL have input clear (1 bit): synchronous abort.
REQ-007 The block SHALL have output rk_valid (1 bit): round key presented.
REQ-008 The block SHALL have input rk_ready (1 bit): consumer accepts rk_data.
REQ-009 The block SHALL have output rk_data (128 bits): round key, packed as key_in.
REQ-010 The block SHALL have output rk_idx (4 bits): round number of rk_data, 10 down to 0.
REQ-011 The block SHALL have output busy (1 bit): high in any state other than IDLE.
REQ-012 The block SHALL have output done (1 bit): single-cycle pulse after round 0 is accepted.

Function
REQ-013 The block SHALL have states IDLE, EMIT and SUB, and SHALL enter IDLE on reset.
REQ-014 On a start handshake (start_valid && start_ready), the block SHALL capture key_in into the key register, set round to 10, and go to EMIT.
REQ-015 In EMIT, the block SHALL drive rk_valid=1, rk_data=key register and rk_idx=round.
REQ-016 While rk_valid && !rk_ready, the block SHALL hold rk_data and rk_idx stable.
REQ-017 On an rk handshake in EMIT with round>0, the block SHALL go to SUB with byte counter 0.
REQ-018 On an rk handshake in EMIT with round=0, the block SHALL go to IDLE and pulse done in the following cycle.
REQ-019 SUB SHALL last exactly 4 cycles and SHALL use one riscv_crypto_aes_fwd_sbox instance (forward S-box, also used for decryption schedules), one byte per cycle.
REQ-020 With current words w0..w3, SUB SHALL form the previous words p3=w3^w2, p2=w2^w1, p1=w1^w0.
REQ-021 In SUB cycle c (0..3), the block SHALL look up byte ((c+1) mod 4) of p3 (RotWord) and store the result as byte c of temporary t.
REQ-022 After the 4th SUB cycle, the block SHALL write p0 = w0 ^ t ^ {24'h0, rcon[round]} and then write {p3,p2,p1,p0}.
REQ-023 After the 4th SUB cycle, the block SHALL decrement round and return to EMIT.
REQ-024 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-025 Latency: rk_valid for round 10 SHALL be asserted in the cycle after the start handshake.
REQ-026 Latency: each subsequent round key SHALL be presented 5 cycles after the previous rk handshake (4 SUB cycles plus 1).
REQ-027 Minimum total time from start to done SHALL be 1+11+40 cycles with rk_ready held high.
REQ-028 start_valid outside IDLE SHALL be ignored; start_ready=0.
REQ-029 clear=1 in any state SHALL force IDLE in the next cycle with rk_valid=0 and no done pulse.
REQ-030 When clear and a start handshake occur in the same cycle, clear SHALL win and the key SHALL NOT be captured.
REQ-031 rk_valid SHALL be 0 in IDLE and SUB.
REQ-032 rk_valid SHALL NOT depend combinationally on rk_ready.

Reset
REQ-033 On g_resetn=0, the block SHALL asynchronously set state=IDLE, rk_valid=0, done=0, busy=0, start_ready=1, rk_idx=0, rk_data=0, round=0 and byte counter=0.
REQ-034 Reset asserted mid-operation SHALL abandon the schedule, and no further rk_valid SHALL be asserted until a new start.

Verification
REQ-035 FIPS-197 round 10: key_in bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6, rk_ready=1 -> first output rk_idx=10, rk_data=the same bytes.
REQ-036 FIPS-197 round 9 (same run): rk_idx=9, bytes ac 77 66 f3 19 fa dc 21 28 d1 29 41 57 5c 00 6e, exactly 5 cycles after the round-10 handshake.
REQ-037 FIPS-197 round 0 (same run): rk_idx=0, bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c; done pulses once; total 52 cycles from start to done.
REQ-038 Backpressure: rk_ready=0 for 7 cycles at round 6 -> rk_data and rk_idx stable throughout; results identical to REQ-035..REQ-037.
REQ-039 Abort: clear during SUB of round 4 -> IDLE next cycle, no done; a new start then reproduces the full sequence.
REQ-040 Reset and start interaction: g_resetn pulsed low in EMIT -> all outputs at reset values immediately; start_valid asserted while busy -> ignored, schedule unaffected.
